// File: rtl/riscv_pkg.sv
// Shared execute-stage types: datapath width, ALU op codes, forwarding selects, MUL FSM states.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_WB     = 2'b01,
        FWD_MEM    = 2'b10,
        FWD_RF_ALT = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// Operand/result bundle between the execute stage and its combinational ALU.
// Zero latency, no flow control: the master drives op/a/b, the slave returns y.
interface ex_stage_if #(parameter int XLEN = 32);
    riscv_pkg::alu_op_t op;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [XLEN-1:0]    y;

    modport master (output op, a, b, input y);
    modport slave  (input op, a, b, output y);
endinterface

// File: rtl/alu.sv
// Combinational integer ALU for ops 0-9; every other op code (MUL included) yields 0.
// Zero latency, no backpressure.
module alu import riscv_pkg::*; #(
    parameter int XLEN = 32
) (
    ex_stage_if.slave bus
);

    logic [4:0] shamt;

    always_comb begin
        shamt  = bus.b[4:0];
        bus.y  = '0;
        case (bus.op)
            ALU_ADD:  bus.y = bus.a + bus.b;
            ALU_SUB:  bus.y = bus.a - bus.b;
            ALU_SLL:  bus.y = bus.a << shamt;
            ALU_SLT:  bus.y = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU: bus.y = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            ALU_XOR:  bus.y = bus.a ^ bus.b;
            ALU_SRL:  bus.y = bus.a >> shamt;
            ALU_SRA:  bus.y = $unsigned($signed(bus.a) >>> shamt);
            ALU_OR:   bus.y = bus.a | bus.b;
            ALU_AND:  bus.y = bus.a & bus.b;
            default:  bus.y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM register; 1 cycle, MUL 34 cycles with RV32M_EN.
// mem_stall freezes EX/MEM; ex_busy asks upstream to hold while a multiply is in flight.
module ex_stage import riscv_pkg::*; #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [3:0]      id_alu_op,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [4:0]      id_rd,
    input  logic            id_regwrite,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            mem_stall,
    input  logic            flush,
    output logic            ex_busy,
    output logic            exmem_valid,
    output logic [XLEN-1:0] exmem_result,
    output logic [XLEN-1:0] exmem_store_data,
    output logic [4:0]      exmem_rd,
    output logic            exmem_regwrite
);

    function automatic logic [XLEN-1:0] fwd_pick(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                                 input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
        case (fwd_sel_t'(sel))
            FWD_MEM: return mem;
            FWD_WB:  return wb;
            default: return rf;
        endcase
    endfunction

    logic [XLEN-1:0] op_a, rs2_fwd, op_b;
    assign op_a    = fwd_pick(fwd_a, id_rs1_data, mem_fwd_data, wb_fwd_data);
    assign rs2_fwd = fwd_pick(fwd_b, id_rs2_data, mem_fwd_data, wb_fwd_data);
    // Immediate substitution comes after forwarding so stores still see the forwarded rs2.
    assign op_b    = id_alu_src ? id_imm : rs2_fwd;

    ex_stage_if #(.XLEN(XLEN)) alu_bus ();
    assign alu_bus.op = alu_op_t'(id_alu_op);
    assign alu_bus.a  = op_a;
    assign alu_bus.b  = op_b;

    alu #(.XLEN(XLEN)) u_alu (.bus(alu_bus.slave));

    logic            mul_take, mul_hold, mul_wr, mul_rw;
    logic [XLEN-1:0] mul_res;
    logic [4:0]      mul_rd;

`ifdef RV32M_EN
    mul_state_t      state_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
    logic [4:0]      mrd_q;
    logic            mrw_q;

    assign mul_take = (state_q == MUL_IDLE) && id_valid && (id_alu_op == ALU_MUL) && !flush;
    assign mul_hold = (state_q != MUL_IDLE);
    assign mul_wr   = (state_q == MUL_DONE) && !mem_stall && !flush;
    assign mul_res  = acc_q;
    assign mul_rd   = mrd_q;
    assign mul_rw   = mrw_q;
    assign ex_busy  = rst_n && (((state_q == MUL_IDLE) && id_valid && (id_alu_op == ALU_MUL)) ||
                                (state_q == MUL_BUSY) ||
                                ((state_q == MUL_DONE) && mem_stall));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mrd_q    <= '0;
            mrw_q    <= 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE: if (mul_take) begin
                    state_q  <= MUL_BUSY;
                    cnt_q    <= '0;
                    mcand_q  <= op_a;
                    mplier_q <= op_b;
                    acc_q    <= '0;
                    mrd_q    <= id_rd;
                    mrw_q    <= id_regwrite;
                end
                MUL_BUSY: if (flush) begin
                    state_q <= MUL_IDLE;
                end else begin
                    // One shift-add step per cycle, independent of downstream stalls.
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= MUL_DONE;
                end
                MUL_DONE: if (flush || !mem_stall) state_q <= MUL_IDLE;
                default:  state_q <= MUL_IDLE;
            endcase
        end
    end
`else
    assign mul_take = 1'b0;
    assign mul_hold = 1'b0;
    assign mul_wr   = 1'b0;
    assign mul_res  = '0;
    assign mul_rd   = '0;
    assign mul_rw   = 1'b0;
    assign ex_busy  = 1'b0;
`endif

    logic            valid_d, valid_q, regwrite_d, regwrite_q;
    logic [XLEN-1:0] result_d, result_q, store_d, store_q;
    logic [4:0]      rd_d, rd_q;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        result_d   = result_q;
        store_d    = store_q;
        rd_d       = rd_q;
        if (!mem_stall) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            result_d   = '0;
            store_d    = '0;
            rd_d       = '0;
            if (mul_wr) begin
                valid_d    = 1'b1;
                result_d   = mul_res;
                rd_d       = mul_rd;
                regwrite_d = mul_rw && (mul_rd != 5'd0);
            end else if (id_valid && !flush && !mul_take && !mul_hold) begin
                valid_d    = 1'b1;
                result_d   = alu_bus.y;
                store_d    = rs2_fwd;
                rd_d       = id_rd;
                regwrite_d = id_regwrite && (id_rd != 5'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            result_q   <= result_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
        end
    end

    assign exmem_valid      = valid_q;
    assign exmem_regwrite   = regwrite_q;
    assign exmem_result     = result_q;
    assign exmem_store_data = store_q;
    assign exmem_rd         = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, stall/flush, rd=0, MUL timing and reset.
module tb_ex_stage;

    logic        clk, rst_n;
    logic        id_valid, id_alu_src, id_regwrite, mem_stall, flush;
    logic [3:0]  id_alu_op;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, mem_fwd_data, wb_fwd_data;
    logic [4:0]  id_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        ex_busy, exmem_valid, exmem_regwrite;
    logic [31:0] exmem_result, exmem_store_data;
    logic [4:0]  exmem_rd;

    int total = 0;
    int bad   = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .mem_stall(mem_stall), .flush(flush), .ex_busy(ex_busy),
        .exmem_valid(exmem_valid), .exmem_result(exmem_result),
        .exmem_store_data(exmem_store_data), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite)
    );

    ex_stage_if #(.XLEN(32)) tb_alu_bus ();
    alu #(.XLEN(32)) u_tb_alu (.bus(tb_alu_bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw);
        id_valid    = 1'b1;
        id_alu_op   = op;
        id_rs1_data = a;
        id_rs2_data = b;
        id_rd       = rd;
        id_regwrite = rw;
        id_alu_src  = 1'b0;
        id_imm      = '0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
    endtask

    task automatic go_idle();
        id_valid = 1'b0; id_alu_op = 4'd0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_alu_src = 1'b0; id_rd = '0; id_regwrite = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
        mem_fwd_data = '0; wb_fwd_data = '0; mem_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (exmem_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", exmem_valid); end
        total++; if (exmem_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", exmem_result); end
        total++; if (exmem_store_data !== 32'h0) begin bad++; $display("FAIL reset_store got=%h exp=0", exmem_store_data); end
        total++; if (exmem_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", exmem_rd); end
        total++; if (exmem_regwrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%0b exp=0", exmem_regwrite); end
        total++; if (ex_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", ex_busy); end
    endtask

    task automatic test_forwarding();
        drive(4'd0, 32'd100, 32'd5, 5'd3, 1'b1);
        fwd_a = 2'b10; mem_fwd_data = 32'd7;
        step();
        total++; if (exmem_result !== 32'd12) begin bad++; $display("FAIL fwd_mem_add got=%0d exp=12", exmem_result); end
        total++; if (exmem_valid !== 1'b1 || exmem_rd !== 5'd3 || exmem_regwrite !== 1'b1) begin
            bad++; $display("FAIL fwd_ctrl got=%0b/%0d/%0b exp=1/3/1", exmem_valid, exmem_rd, exmem_regwrite); end
        drive(4'd1, 32'd20, 32'd99, 5'd4, 1'b1);
        fwd_b = 2'b01; wb_fwd_data = 32'd3;
        step();
        total++; if (exmem_result !== 32'd17) begin bad++; $display("FAIL fwd_wb_sub got=%0d exp=17", exmem_result); end
        total++; if (exmem_store_data !== 32'd3) begin bad++; $display("FAIL fwd_wb_store got=%0d exp=3", exmem_store_data); end
        drive(4'd0, 32'd1, 32'd77, 5'd4, 1'b1);
        fwd_a = 2'b11; fwd_b = 2'b10; mem_fwd_data = 32'd55; wb_fwd_data = 32'd66;
        id_alu_src = 1'b1; id_imm = 32'd4;
        step();
        total++; if (exmem_result !== 32'd5) begin bad++; $display("FAIL fwd_imm_add got=%0d exp=5", exmem_result); end
        total++; if (exmem_store_data !== 32'd55) begin bad++; $display("FAIL fwd_imm_store got=%0d exp=55", exmem_store_data); end
        go_idle();
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [12] = '{4'd1, 4'd7, 4'd4, 4'd3, 4'd2, 4'd6, 4'd5, 4'd8, 4'd9, 4'd0, 4'd11, 4'd15};
        logic [31:0] av  [12] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h80000000,
                                  32'hF0F0, 32'hF0, 32'hF0, 32'hFFFFFFFF, 32'h1234, 32'h5678};
        logic [31:0] bv  [12] = '{32'h1, 32'h21, 32'h1, 32'h1, 32'h24, 32'h4,
                                  32'h0FF0, 32'h0F, 32'h3C, 32'h2, 32'h1, 32'h2};
        logic [31:0] ev  [12] = '{32'hFFFFFFFF, 32'hC0000000, 32'h0, 32'h1, 32'h10, 32'h08000000,
                                  32'hFF00, 32'hFF, 32'h30, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            drive(ops[i], av[i], bv[i], 5'd8, 1'b1);
            step();
            total++;
            if (exmem_result !== ev[i]) begin
                bad++; $display("FAIL alu_op%0d got=%h exp=%h", ops[i], exmem_result, ev[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_rd_zero();
        drive(4'd0, 32'd1, 32'd1, 5'd0, 1'b1);
        step();
        total++; if (exmem_regwrite !== 1'b0) begin bad++; $display("FAIL rd0_regwrite got=%0b exp=0", exmem_regwrite); end
        total++; if (exmem_valid !== 1'b1) begin bad++; $display("FAIL rd0_valid got=%0b exp=1", exmem_valid); end
        drive(4'd0, 32'd1, 32'd1, 5'd5, 1'b1);
        step();
        total++; if (exmem_regwrite !== 1'b1 || exmem_rd !== 5'd5) begin
            bad++; $display("FAIL rd5_write got=%0b/%0d exp=1/5", exmem_regwrite, exmem_rd); end
        go_idle();
    endtask

    task automatic test_stall_flush();
        drive(4'd0, 32'd3, 32'd4, 5'd7, 1'b1);
        step();
        drive(4'd1, 32'd9, 32'd1, 5'd2, 1'b0);
        mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) id_valid = 1'b0;
            step();
            total++;
            if (exmem_valid !== 1'b1 || exmem_result !== 32'd7 || exmem_store_data !== 32'd4 ||
                exmem_rd !== 5'd7 || exmem_regwrite !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d got=%0b/%0d/%0d/%0d/%0b exp=1/7/4/7/1", c,
                                exmem_valid, exmem_result, exmem_store_data, exmem_rd, exmem_regwrite);
            end
        end
        drive(4'd1, 32'd9, 32'd1, 5'd2, 1'b1);
        mem_stall = 1'b0; flush = 1'b1;
        step();
        total++; if (exmem_valid !== 1'b0 || exmem_regwrite !== 1'b0 || exmem_result !== 32'd0) begin
            bad++; $display("FAIL flush_bubble got=%0b/%0b/%h exp=0/0/0", exmem_valid, exmem_regwrite, exmem_result); end
        flush = 1'b0;
        step();
        total++; if (exmem_result !== 32'd8 || exmem_valid !== 1'b1) begin
            bad++; $display("FAIL after_flush got=%0d/%0b exp=8/1", exmem_result, exmem_valid); end
        id_valid = 1'b0;
        step();
        total++; if (exmem_valid !== 1'b0 || exmem_result !== 32'd0) begin
            bad++; $display("FAIL invalid_bubble got=%0b/%h exp=0/0", exmem_valid, exmem_result); end
        go_idle();
    endtask

`ifdef RV32M_EN
    task automatic test_mul();
        int busy_cnt  = 0;
        int done_edge = 0;
        drive(4'd10, 32'h0000FFFF, 32'h00010001, 5'd9, 1'b1);
        #1;
        if (ex_busy) busy_cnt++;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (exmem_valid) begin done_edge = e; break; end
            if (ex_busy) busy_cnt++;
        end
        go_idle();
        total++; if (done_edge != 34) begin bad++; $display("FAIL mul_edge got=%0d exp=34", done_edge); end
        total++; if (busy_cnt != 33) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=33", busy_cnt); end
        total++; if (exmem_result !== 32'hFFFFFFFF) begin bad++; $display("FAIL mul_result got=%h exp=ffffffff", exmem_result); end
        total++; if (exmem_rd !== 5'd9 || exmem_regwrite !== 1'b1) begin
            bad++; $display("FAIL mul_dest got=%0d/%0b exp=9/1", exmem_rd, exmem_regwrite); end
        step();
    endtask

    task automatic test_reset_mid_busy();
        drive(4'd10, 32'd6, 32'd7, 5'd9, 1'b1);
        for (int e = 0; e < 5; e++) step();
        total++; if (ex_busy !== 1'b1) begin bad++; $display("FAIL busy_before_rst got=%0b exp=1", ex_busy); end
        rst_n = 1'b0;
        #1;
        total++; if (ex_busy !== 1'b0) begin bad++; $display("FAIL busy_in_rst got=%0b exp=0", ex_busy); end
        total++; if (exmem_valid !== 1'b0 || exmem_result !== 32'd0) begin
            bad++; $display("FAIL rst_outputs got=%0b/%h exp=0/0", exmem_valid, exmem_result); end
        drive(4'd0, 32'd2, 32'd3, 5'd1, 1'b1);
        #1 rst_n = 1'b1;
        total++; if (ex_busy !== 1'b0) begin bad++; $display("FAIL busy_after_rst got=%0b exp=0", ex_busy); end
        step();
        total++; if (exmem_result !== 32'd5 || exmem_valid !== 1'b1) begin
            bad++; $display("FAIL add_after_rst got=%0d/%0b exp=5/1", exmem_result, exmem_valid); end
        go_idle();
    endtask
`else
    task automatic test_mul();
        drive(4'd10, 32'h0000FFFF, 32'h00010001, 5'd9, 1'b1);
        #1;
        total++; if (ex_busy !== 1'b0) begin bad++; $display("FAIL nomul_busy got=%0b exp=0", ex_busy); end
        step();
        total++; if (exmem_valid !== 1'b1 || exmem_result !== 32'd0) begin
            bad++; $display("FAIL nomul_result got=%0b/%h exp=1/0", exmem_valid, exmem_result); end
        go_idle();
    endtask

    task automatic test_reset_mid_busy();
        drive(4'd0, 32'd10, 32'd20, 5'd6, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        total++; if (exmem_valid !== 1'b0 || exmem_result !== 32'd0 || exmem_rd !== 5'd0) begin
            bad++; $display("FAIL async_rst got=%0b/%h/%0d exp=0/0/0", exmem_valid, exmem_result, exmem_rd); end
        drive(4'd0, 32'd2, 32'd3, 5'd1, 1'b1);
        #1 rst_n = 1'b1;
        step();
        total++; if (exmem_result !== 32'd5 || exmem_valid !== 1'b1) begin
            bad++; $display("FAIL add_after_rst got=%0d/%0b exp=5/1", exmem_result, exmem_valid); end
        go_idle();
    endtask
`endif

    task automatic test_alu_direct();
        tb_alu_bus.op = riscv_pkg::ALU_SLT;
        tb_alu_bus.a  = 32'h00000005;
        tb_alu_bus.b  = 32'hFFFFFFFE;
        #1;
        total++; if (tb_alu_bus.y !== 32'd0) begin bad++; $display("FAIL alu_slt_pos_neg got=%h exp=0", tb_alu_bus.y); end
        tb_alu_bus.op = riscv_pkg::ALU_SRL;
        tb_alu_bus.a  = 32'hF0000000;
        tb_alu_bus.b  = 32'h0000003C;
        #1;
        total++; if (tb_alu_bus.y !== 32'h0000000F) begin bad++; $display("FAIL alu_srl28 got=%h exp=f", tb_alu_bus.y); end
    endtask

    initial begin
        rst_n = 1'b0;
        go_idle();
        tb_alu_bus.op = riscv_pkg::ALU_ADD;
        tb_alu_bus.a  = '0;
        tb_alu_bus.b  = '0;
        #12;
        test_reset();
        rst_n = 1'b1;
        step();
        test_forwarding();
        test_alu_ops();
        test_rd_zero();
        test_stall_flush();
        test_mul();
        test_reset_mid_busy();
        test_alu_direct();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
